// File: rtl/serial_char_transmitter.sv
// serial_char_transmitter: one-deep buffered async byte transmitter, idle-high line, LSB first.
// Build with SERIAL_TX_PARITY_EN defined to append an even-parity bit before the stop bit.
module serial_char_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic       transmit,
    output logic       serial_out,
    output logic [3:0] bics,
    output logic       busy,
    output logic       hold_valid,
    output logic       overrun
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bics_q, bics_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_valid_q, hold_valid_d;
    logic            overrun_q, overrun_d;
    logic            start, tick;
`ifdef SERIAL_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif
    assign start = (state_q == IDLE) && transmit && hold_valid_q;
    assign tick  = timer_q == TW'(CLKS_PER_BIT - 1);
    // A load in the frame-start cycle refills the buffer, so it is not an overrun.
    assign hold_d       = load ? data_in : hold_q;
    assign hold_valid_d = load ? 1'b1 : start ? 1'b0 : hold_valid_q;
    assign overrun_d    = overrun_q | (load & hold_valid_q & ~start);
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bics_d  = bics_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == IDLE) begin
            timer_d = '0;
            if (start) begin
                state_d = START;
                shift_d = hold_q;
                bics_d  = 4'd0;
`ifdef SERIAL_TX_PARITY_EN
                parity_d = ^hold_q;
`endif
            end
        end else begin
            timer_d = tick ? '0 : timer_q + 1'b1;
            if (tick) begin
                bics_d = bics_q + 4'd1;
                case (state_q)
                    START:   state_d = DATA;
                    DATA: begin
                        shift_d = shift_q >> 1;
`ifdef SERIAL_TX_PARITY_EN
                        if (bics_q == 4'(DATA_BITS)) state_d = PARITY;
`else
                        if (bics_q == 4'(DATA_BITS)) state_d = STOP;
`endif
                    end
                    PARITY:  state_d = STOP;
                    STOP:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bics_q       <= 4'd0;
            shift_q      <= 8'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bics_q       <= bics_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            overrun_q    <= overrun_d;
        end
    end
`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) parity_q <= 1'b0;
        else             parity_q <= parity_d;
    end
    assign serial_out = (state_q == START)  ? 1'b0 :
                        (state_q == DATA)   ? shift_q[0] :
                        (state_q == PARITY) ? parity_q : 1'b1;
`else
    assign serial_out = (state_q == START) ? 1'b0 :
                        (state_q == DATA)  ? shift_q[0] : 1'b1;
`endif
    assign bics       = bics_q;
    assign busy       = state_q != IDLE;
    assign hold_valid = hold_valid_q;
    assign overrun    = overrun_q;
endmodule
